// File: rtl/cpu_types_pkg.sv
// Shared CPU types: the machine word and the MEM-stage access FSM states.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_acc_state_t;
endpackage

// File: rtl/mem_access_unit.sv
// MEM-stage dcache access sequencer: issues each access once, stalls until dhit, holds load/SC data.
// Optional perf counters (acc_count, stall_count) are built when MEM_ACCESS_PERF_EN is defined.
module mem_access_unit
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
`ifdef MEM_ACCESS_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              MemRead_MEM,
  input  logic              MemWr_MEM,
  input  logic              datomic_MEM,
  input  logic [WORD_W-1:0] alu_out_MEM,
  input  logic [WORD_W-1:0] busB_MEM,
  input  logic              advance,
  input  logic              flush_MEM,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic              datomic,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] mem_load_data,
`ifdef MEM_ACCESS_PERF_EN
  output logic [CNT_W-1:0]  acc_count,
  output logic [CNT_W-1:0]  stall_count,
`endif
  output logic              mem_stall
);

  mem_acc_state_t    state_q, state_d;
  logic [WORD_W-1:0] held_q, held_d;
  logic              opValid, captureEn;
  logic              renC, wenC, atomC, stallC;

  // Read wins if both controls are set; SC returns a success flag so it is captured too.
  assign opValid   = (MemRead_MEM | MemWr_MEM) & ~flush_MEM;
  assign captureEn = MemRead_MEM | (MemWr_MEM & datomic_MEM);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    renC    = 1'b0;
    wenC    = 1'b0;
    atomC   = 1'b0;
    stallC  = 1'b0;
    case (state_q)
      IDLE: begin
        if (opValid) begin
          renC  = MemRead_MEM;
          wenC  = MemWr_MEM & ~MemRead_MEM;
          atomC = datomic_MEM;
          if (dhit) begin
            if (captureEn) held_d = dmemload;
            state_d = advance ? IDLE : DONE;
          end else begin
            stallC  = 1'b1;
            state_d = WAIT;
          end
        end
      end
      // The cache cannot cancel, so flush is ignored until the access lands.
      WAIT: begin
        renC  = MemRead_MEM;
        wenC  = MemWr_MEM & ~MemRead_MEM;
        atomC = datomic_MEM;
        if (dhit) begin
          if (captureEn) held_d = dmemload;
          state_d = advance ? IDLE : DONE;
        end else begin
          stallC = 1'b1;
        end
      end
      DONE: begin
        if (advance | flush_MEM) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gating with nRST drops the request the instant reset asserts, even mid-WAIT.
  assign dmemREN       = renC & nRST;
  assign dmemWEN       = wenC & nRST;
  assign datomic       = atomC & nRST;
  assign mem_stall     = stallC & nRST;
  assign dmemaddr      = alu_out_MEM;
  assign dmemstore     = busB_MEM;
  assign mem_load_data = !nRST ? '0 : ((state_q == DONE) ? held_q : dmemload);

`ifdef MEM_ACCESS_PERF_EN
  logic             accDone;
  logic [CNT_W-1:0] acc_q, stall_q;

  assign accDone = dhit & (((state_q == IDLE) & opValid) | (state_q == WAIT));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      acc_q   <= '0;
      stall_q <= '0;
    end else begin
      if (accDone && (acc_q != '1))  acc_q   <= acc_q + 1'b1;
      if (stallC && (stall_q != '1)) stall_q <= stall_q + 1'b1;
    end
  end

  assign acc_count   = acc_q;
  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit; perf counter scenario is built when MEM_ACCESS_PERF_EN is defined.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        MemRead_MEM, MemWr_MEM, datomic_MEM, advance, flush_MEM, dhit;
  logic [31:0] alu_out_MEM, busB_MEM, dmemload;
  logic        dmemREN, dmemWEN, datomic, mem_stall;
  logic [31:0] dmemaddr, dmemstore, mem_load_data;
`ifdef MEM_ACCESS_PERF_EN
  logic [31:0] acc_count, stall_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] expQ[$];
  logic [31:0] expVal;

  mem_access_unit dut (
    .CLK(CLK), .nRST(nRST),
    .MemRead_MEM(MemRead_MEM), .MemWr_MEM(MemWr_MEM), .datomic_MEM(datomic_MEM),
    .alu_out_MEM(alu_out_MEM), .busB_MEM(busB_MEM),
    .advance(advance), .flush_MEM(flush_MEM), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_load_data(mem_load_data),
`ifdef MEM_ACCESS_PERF_EN
    .acc_count(acc_count), .stall_count(stall_count),
`endif
    .mem_stall(mem_stall)
  );

  always #5 CLK = ~CLK;

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idleInputs();
    MemRead_MEM = 0; MemWr_MEM = 0; datomic_MEM = 0; advance = 0;
    flush_MEM = 0; dhit = 0; dmemload = 32'h0; alu_out_MEM = 32'h0; busB_MEM = 32'h0;
  endtask

  task automatic test_reset();
    idleInputs();
    nRST = 0;
    MemRead_MEM = 1; dhit = 1; dmemload = 32'hCAFE0001;
    @(negedge CLK);
    checks++; if (dmemREN !== 1'b0) begin errors++; $display("[TB] FAIL reset_ren got %b exp 0", dmemREN); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b exp 0", mem_stall); end
    checks++; if (mem_load_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data got %h exp 0", mem_load_data); end
    tick();
    idleInputs();
    nRST = 1;
    tick();
  endtask

  task automatic test_load_hit();
    MemRead_MEM = 1; alu_out_MEM = 32'h100; dhit = 1; dmemload = 32'h11112222; advance = 1;
    expQ.push_back(32'h11112222);
    @(negedge CLK);
    checks++; if (dmemREN !== 1'b1) begin errors++; $display("[TB] FAIL load_hit_ren got %b exp 1", dmemREN); end
    checks++; if (dmemWEN !== 1'b0) begin errors++; $display("[TB] FAIL load_hit_wen got %b exp 0", dmemWEN); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("[TB] FAIL load_hit_stall got %b exp 0", mem_stall); end
    checks++; if (dmemaddr !== 32'h100) begin errors++; $display("[TB] FAIL load_hit_addr got %h exp 100", dmemaddr); end
    expVal = expQ.pop_front();
    checks++; if (mem_load_data !== expVal) begin errors++; $display("[TB] FAIL load_hit_data got %h exp %h", mem_load_data, expVal); end
    tick();
    idleInputs(); dmemload = 32'h0000AAAA;
    @(negedge CLK);
    checks++; if (dmemREN !== 1'b0) begin errors++; $display("[TB] FAIL load_hit_after_ren got %b exp 0", dmemREN); end
    checks++; if (mem_load_data !== 32'h0000AAAA) begin errors++; $display("[TB] FAIL load_hit_idle_data got %h exp 0000aaaa", mem_load_data); end
    tick();
  endtask

  task automatic test_store_miss();
    int stalls = 0;
    int wenCycles = 0;
    MemWr_MEM = 1; alu_out_MEM = 32'h200; busB_MEM = 32'hDEADBEEF; dhit = 0; advance = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (mem_stall === 1'b1) stalls++;
      if (dmemWEN === 1'b1) wenCycles++;
      tick();
    end
    dhit = 1; advance = 1;
    @(negedge CLK);
    if (dmemWEN === 1'b1) wenCycles++;
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("[TB] FAIL store_miss_hit_stall got %b exp 0", mem_stall); end
    checks++; if (dmemstore !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL store_miss_data got %h exp deadbeef", dmemstore); end
    checks++; if (stalls !== 3) begin errors++; $display("[TB] FAIL store_miss_stall_cycles got %0d exp 3", stalls); end
    checks++; if (wenCycles !== 4) begin errors++; $display("[TB] FAIL store_miss_wen_cycles got %0d exp 4", wenCycles); end
    tick();
    idleInputs();
    @(negedge CLK);
    checks++; if (dmemWEN !== 1'b0) begin errors++; $display("[TB] FAIL store_miss_after_wen got %b exp 0", dmemWEN); end
    tick();
  endtask

  task automatic test_store_done();
    int wenCycles = 0;
    int stallSeen = 0;
    MemWr_MEM = 1; alu_out_MEM = 32'h300; busB_MEM = 32'h0BADF00D; dhit = 1; advance = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (dmemWEN === 1'b1) wenCycles++;
      if (mem_stall === 1'b1) stallSeen++;
      tick();
      dhit = 0;
    end
    checks++; if (wenCycles !== 1) begin errors++; $display("[TB] FAIL store_done_wen_cycles got %0d exp 1", wenCycles); end
    checks++; if (stallSeen !== 0) begin errors++; $display("[TB] FAIL store_done_stall_cycles got %0d exp 0", stallSeen); end
    advance = 1;
    tick();
    idleInputs(); dmemload = 32'h00005555;
    @(negedge CLK);
    checks++; if (mem_load_data !== 32'h00005555) begin errors++; $display("[TB] FAIL store_done_idle_data got %h exp 00005555", mem_load_data); end
    tick();
  endtask

  task automatic test_load_hold();
    MemRead_MEM = 1; alu_out_MEM = 32'h400; dhit = 1; dmemload = 32'h1234; advance = 0;
    expQ.push_back(32'h1234);
    @(negedge CLK);
    expVal = expQ.pop_front();
    checks++; if (mem_load_data !== expVal) begin errors++; $display("[TB] FAIL hold_hit_data got %h exp %h", mem_load_data, expVal); end
    tick();
    dhit = 0; dmemload = 32'hFFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++; if (mem_load_data !== expVal) begin errors++; $display("[TB] FAIL hold_done_data got %h exp %h", mem_load_data, expVal); end
      checks++; if (dmemREN !== 1'b0) begin errors++; $display("[TB] FAIL hold_done_ren got %b exp 0", dmemREN); end
      tick();
    end
    advance = 1;
    tick();
    idleInputs();
    tick();
  endtask

  task automatic test_sc_flush();
    MemWr_MEM = 1; datomic_MEM = 1; alu_out_MEM = 32'h500; busB_MEM = 32'h42; dhit = 0; advance = 0;
    @(negedge CLK);
    checks++; if ({dmemWEN, datomic, mem_stall} !== 3'b111) begin errors++; $display("[TB] FAIL sc_issue got %b exp 111", {dmemWEN, datomic, mem_stall}); end
    tick();
    flush_MEM = 1;
    @(negedge CLK);
    checks++; if ({dmemWEN, mem_stall} !== 2'b11) begin errors++; $display("[TB] FAIL sc_flush_wait got %b exp 11", {dmemWEN, mem_stall}); end
    tick();
    dhit = 1; dmemload = 32'h1;
    expQ.push_back(32'h1);
    @(negedge CLK);
    expVal = expQ.pop_front();
    checks++; if ({dmemWEN, datomic, mem_stall} !== 3'b110) begin errors++; $display("[TB] FAIL sc_hit_ctrl got %b exp 110", {dmemWEN, datomic, mem_stall}); end
    checks++; if (mem_load_data !== expVal) begin errors++; $display("[TB] FAIL sc_hit_data got %h exp %h", mem_load_data, expVal); end
    tick();
    dhit = 0; dmemload = 32'h0;
    @(negedge CLK);
    checks++; if (mem_load_data !== expVal) begin errors++; $display("[TB] FAIL sc_done_data got %h exp %h", mem_load_data, expVal); end
    checks++; if (dmemWEN !== 1'b0) begin errors++; $display("[TB] FAIL sc_done_wen got %b exp 0", dmemWEN); end
    tick();
    dmemload = 32'h77;
    @(negedge CLK);
    checks++; if ({dmemWEN, mem_stall} !== 2'b00) begin errors++; $display("[TB] FAIL sc_flush_idle_ctrl got %b exp 00", {dmemWEN, mem_stall}); end
    checks++; if (mem_load_data !== 32'h77) begin errors++; $display("[TB] FAIL sc_flush_idle_data got %h exp 00000077", mem_load_data); end
    tick();
    idleInputs();
    tick();
  endtask

  task automatic test_reset_mid_wait();
    MemRead_MEM = 1; alu_out_MEM = 32'h600; dhit = 0;
    tick();
    @(negedge CLK);
    checks++; if ({dmemREN, mem_stall} !== 2'b11) begin errors++; $display("[TB] FAIL rst_wait_pre got %b exp 11", {dmemREN, mem_stall}); end
    #2 nRST = 0;
    #1;
    checks++; if ({dmemREN, dmemWEN, mem_stall} !== 3'b000) begin errors++; $display("[TB] FAIL rst_wait_drop got %b exp 000", {dmemREN, dmemWEN, mem_stall}); end
    tick();
    idleInputs();
    nRST = 1;
    tick();
  endtask

`ifdef MEM_ACCESS_PERF_EN
  task automatic test_perf();
    checks++; if ({acc_count, stall_count} !== 64'h0) begin errors++; $display("[TB] FAIL perf_reset got %h exp 0", {acc_count, stall_count}); end
    MemRead_MEM = 1; dhit = 1; advance = 1;
    tick();
    idleInputs(); MemWr_MEM = 1;
    for (int i = 0; i < 3; i++) tick();
    dhit = 1; advance = 1;
    tick();
    idleInputs();
    @(negedge CLK);
    checks++; if (acc_count !== 32'd2) begin errors++; $display("[TB] FAIL perf_acc got %0d exp 2", acc_count); end
    checks++; if (stall_count !== 32'd3) begin errors++; $display("[TB] FAIL perf_stall got %0d exp 3", stall_count); end
    tick();
  endtask
`endif

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout exp completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_load_hit();
    test_store_miss();
    test_store_done();
    test_load_hold();
    test_sc_flush();
    test_reset_mid_wait();
`ifdef MEM_ACCESS_PERF_EN
    test_perf();
`endif
    checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_drain got %0d exp 0", expQ.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
